// File: rtl/led_pattern_sequencer_pkg.sv
// Shared constants for the LED pattern sequencer: slave register map, CTRL bit
// positions, PIO register offset and FSM state encoding.
package led_pattern_sequencer_pkg;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_PERIOD  = 2'd1;
   localparam logic [1:0] REG_LENGTH  = 2'd2;
   localparam logic [1:0] REG_PATTERN = 2'd3;

   localparam int unsigned CTRL_RUN  = 0;
   localparam int unsigned CTRL_LOOP = 1;
   localparam int unsigned CTRL_BUSY = 2;

   localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WRITE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/led_step_timer.sv
// Loadable down-counter for the step period; saturates at zero and exposes a
// registered zero flag.
module led_step_timer #(
   parameter int unsigned W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);

   logic [W-1:0] count_q, count_d;
   logic         zero_q;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         zero_q  <= 1'b1;
      end else begin
         count_q <= count_d;
         zero_q  <= (count_d == '0);
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Plays a programmable list of LED patterns into the PIO data register, one
// step per PERIOD clocks, through a write master that honours waitrequest.
module led_pattern_sequencer
   import led_pattern_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned LED_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata,
   input  logic        m_waitrequest,
   output logic        busy
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned LEN_W = $clog2(DEPTH) + 1;

   logic [1:0]          state_q, state_d;
   logic                run_q, run_d, loop_q, loop_d, busy_q;
   logic [PERIOD_W-1:0] period_q, period_d, period_eff;
   logic [LEN_W-1:0]    length_q, length_d, len_wr_val;
   logic [IDX_W-1:0]    index_q, index_d, next_idx;
   logic [LED_W-1:0]    pat_q [DEPTH];
   logic                m_cs_q, m_cs_d, m_wr_n_q, m_wr_n_d;
   logic [LED_W-1:0]    m_data_q, m_data_d;
   logic                wr_en, ctrl_wr, period_wr, length_wr, pat_wr;
   logic                tmr_load, tmr_en, tmr_zero, last_step;
   logic                unused_wdata;

   assign wr_en     = s_chipselect & ~s_write_n;
   assign ctrl_wr   = wr_en && (s_address == REG_CTRL);
   assign period_wr = wr_en && (s_address == REG_PERIOD);
   assign length_wr = wr_en && (s_address == REG_LENGTH);
   assign pat_wr    = wr_en && (s_address == REG_PATTERN);
   assign unused_wdata = ^s_writedata;

   // LENGTH is clamped into 1..DEPTH on write.
   always_comb begin
      if (s_writedata == 32'd0) begin
         len_wr_val = LEN_W'(1);
      end else if (s_writedata > 32'(DEPTH)) begin
         len_wr_val = LEN_W'(DEPTH);
      end else begin
         len_wr_val = LEN_W'(s_writedata);
      end
   end

   assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
   assign last_step  = (LEN_W'(index_q) == (length_q - LEN_W'(1)));
   assign next_idx   = last_step ? '0 : (index_q + IDX_W'(1));

   led_step_timer #(.W(PERIOD_W)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load_i    (tmr_load),
      .load_val_i(period_eff - PERIOD_W'(1)),
      .en_i      (tmr_en),
      .zero_o    (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      loop_d   = loop_q;
      period_d = period_q;
      length_d = length_q;
      index_d  = index_q;
      m_cs_d   = m_cs_q;
      m_wr_n_d = m_wr_n_q;
      m_data_d = m_data_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;

      // While busy, a CTRL write can only clear run, never restart the sequence.
      if (ctrl_wr) begin
         loop_d = s_writedata[CTRL_LOOP];
         run_d  = (state_q == ST_IDLE) ? s_writedata[CTRL_RUN]
                                       : (run_q & s_writedata[CTRL_RUN]);
      end
      if (period_wr) period_d = s_writedata[PERIOD_W-1:0];
      if (length_wr) length_d = len_wr_val;

      case (state_q)
         ST_IDLE: begin
            if (run_d) begin
               index_d  = '0;
               m_data_d = pat_q[0];
               m_cs_d   = 1'b1;
               m_wr_n_d = 1'b0;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (!m_waitrequest) begin
               m_cs_d   = 1'b0;
               m_wr_n_d = 1'b1;
               if (run_d) begin
                  tmr_load = 1'b1;
                  state_d  = ST_WAIT;
               end else begin
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            if (!run_d) begin
               state_d = ST_IDLE;
            end else if (tmr_zero) begin
               if (last_step && !loop_q) begin
                  run_d   = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  index_d  = next_idx;
                  m_data_d = pat_q[next_idx];
                  m_cs_d   = 1'b1;
                  m_wr_n_d = 1'b0;
                  state_d  = ST_WRITE;
               end
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         run_q    <= 1'b0;
         loop_q   <= 1'b0;
         busy_q   <= 1'b0;
         period_q <= PERIOD_W'(1);
         length_q <= LEN_W'(DEPTH);
         index_q  <= '0;
         m_cs_q   <= 1'b0;
         m_wr_n_q <= 1'b1;
         m_data_q <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         loop_q   <= loop_d;
         busy_q   <= (state_d != ST_IDLE);
         period_q <= period_d;
         length_q <= length_d;
         index_q  <= index_d;
         m_cs_q   <= m_cs_d;
         m_wr_n_q <= m_wr_n_d;
         m_data_q <= m_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) pat_q[i] <= '0;
      end else if (pat_wr) begin
         pat_q[s_writedata[24 +: IDX_W]] <= s_writedata[LED_W-1:0];
      end
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         REG_CTRL: begin
            s_readdata[CTRL_RUN]  = run_q;
            s_readdata[CTRL_LOOP] = loop_q;
            s_readdata[CTRL_BUSY] = busy_q;
         end
         REG_PERIOD:  s_readdata = 32'(period_q);
         REG_LENGTH:  s_readdata = 32'(length_q);
         REG_PATTERN: s_readdata = 32'(pat_q[index_q]);
         default:     s_readdata = '0;
      endcase
   end

   assign m_address    = PIO_DATA_OFFSET;
   assign m_chipselect = m_cs_q;
   assign m_write_n    = m_wr_n_q;
   assign m_writedata  = 32'(m_data_q);
   assign busy         = busy_q;

endmodule
